// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter: direction FSM states and end-of-range modes.
package updown_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is unused and decays to ST_HOLD on the next edge.
    typedef enum logic [STATE_W-1:0] {
        ST_HOLD = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } dir_state_t;

    localparam int WRAP_SAT  = 0;
    localparam int WRAP_MOD  = 1;

endpackage

// File: rtl/updown_dir_fsm.sv
// Direction FSM: decodes up/down request levels into HOLD/UP/DOWN.
// The new state and the registered dir/running flags appear one edge after the request.
module updown_dir_fsm
    import updown_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               up_req_i,
    input  logic               down_req_i,
    output logic [STATE_W-1:0] state_o,
    output logic               dir_o,
    output logic               running_o
);

    dir_state_t state_q;
    dir_state_t state_d;
    logic       dir_q;
    logic       running_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD, ST_UP, ST_DOWN: begin
                if (up_req_i && !down_req_i)
                    state_d = ST_UP;
                else if (down_req_i && !up_req_i)
                    state_d = ST_DOWN;
                else if (up_req_i && down_req_i)
                    state_d = ST_HOLD;
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= (state_d == ST_UP);
            running_q <= (state_d == ST_UP) || (state_d == ST_DOWN);
        end
    end

    assign state_o   = state_q;
    assign dir_o     = dir_q;
    assign running_o = running_q;

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter; direction comes from updown_dir_fsm and takes effect one edge later.
// Ends wrap (WRAP=1) or saturate (WRAP=0); tc pulses for one cycle after each wrap or blocked step.
module updown_counter
    import updown_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_req,
    input  logic             down_req,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             running,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic [STATE_W-1:0] state;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic               tc_q;
    logic               tc_d;
    logic               step_en;
    logic               cnt_en;

    updown_dir_fsm u_dir_fsm (
        .clk        (clk),
        .reset      (reset),
        .up_req_i   (up_req),
        .down_req_i (down_req),
        .state_o    (state),
        .dir_o      (dir),
        .running_o  (running)
    );

    assign at_max  = (count_q == CNT_MAX);
    assign at_min  = (count_q == CNT_MIN);
    assign step_en = ena && running;
    assign cnt_en  = load || step_en;

    // Stepping uses the state held before the edge, so a new request steps one edge later.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (step_en && (state == ST_UP)) begin
            if (at_max) begin
                count_d = (WRAP == WRAP_MOD) ? CNT_MIN : CNT_MAX;
                tc_d    = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (step_en && (state == ST_DOWN)) begin
            if (at_min) begin
                count_d = (WRAP == WRAP_MOD) ? CNT_MAX : CNT_MIN;
                tc_d    = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            if (cnt_en)
                count_q <= count_d;
            tc_q <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Loadable up/down counter with direction set by a small Moore FSM.
- Pulse requests select counting up, counting down or hold.
- Wraps or saturates at the range ends; flags the limits and each wrap/blocked step.
- Used by the lab top level as the count source for displays and sequencing; built on enable-gated D-flop registers.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..8).
- WRAP, 1, 1 = modular wrap at the ends, 0 = saturate at 0 / 2^WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  count enable; gates stepping only
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value captured on load
- up_req  in  1  request direction UP (level sampled each edge)
- down_req  in  1  request direction DOWN
- count  out  WIDTH  registered counter value
- dir  out  1  1 when FSM is UP, else 0
- running  out  1  1 when FSM is UP or DOWN
- at_max  out  1  combinational: count == 2^WIDTH-1
- at_min  out  1  combinational: count == 0
- tc  out  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset forces count=0, FSM=HOLD, tc=0, so dir=0, running=0, at_min=1, at_max=0.
- Reset asserted mid-count clears everything immediately. The first step after release occurs only after a new up_req or down_req.
- FSM states: HOLD=00, UP=01, DOWN=10; 11 is illegal and recovers to HOLD on the next edge.
- FSM transitions at each edge:
  - up_req & !down_req -> UP
  - down_req & !up_req -> DOWN
  - up_req & down_req -> HOLD
  - neither -> stay
- ena and load do not affect the FSM.
- Count update priority at each edge:
  1. load=1: count <= load_val, tc <= 0, regardless of ena or state.
  2. ena=1 and state UP: count+1.
  3. ena=1 and state DOWN: count-1.
  4. Otherwise hold; tc <= 0.
- The step uses the state held before the edge. A direction request at edge k therefore produces its first step in the new direction at edge k+1 (one-cycle latency).
- Wrap mode (WRAP=1):
  - UP at max -> 0, tc <= 1.
  - DOWN at 0 -> max, tc <= 1.
- Saturate mode (WRAP=0):
  - UP at max stays at max, tc <= 1.
  - DOWN at 0 stays at 0, tc <= 1.
  - tc repeats every cycle while stepping remains blocked.
- Any other step: tc <= 0. tc is high for exactly the cycle after the qualifying edge.
- Arithmetic is modulo 2^WIDTH; no internal width extension is visible at the ports.
- load at the same edge as a direction request: count takes load_val and the FSM takes the new state; stepping resumes next edge.

Decomposition:
- Package updown_pkg:
  - state encoding constants HOLD/UP/DOWN and the state width (2)
  - WRAP mode constants
- Sub-module updown_dir_fsm: request decode plus 2-bit state register; outputs state, dir, running.
- Top level holds:
  - the count register (enable = load | ena&running)
  - next-count mux
  - limit compare
  - tc register

Test Plan:
- Reset then up_req one cycle, ena=1 for 5 edges (WIDTH=4) -> count 0,0,1,2,3,4 (first step one edge after the request); dir=1, running=1.
- WRAP=1, load 4'hE, UP, 3 steps -> count F,0,1; tc high only in the cycle after F->0; at_max high while count=F.
- WRAP=0, load 4'h1, DOWN, 4 steps -> count 0,0,0,0; tc high in the three cycles after each blocked step; at_min=1.
- up_req and down_req together while UP at count=7 -> state HOLD; count holds at 8 (one in-flight step) thereafter; running=0.
- load=1 with load_val=4'h9 while ena=1 and UP at count=3 -> count=9 (load wins), tc=0; next edge count=A.
- Assert reset asynchronously mid-cycle at count=6 in DOWN -> count=0, FSM HOLD, tc=0 immediately without a clock edge; no steps after release until a new request.
